lcd_text_driver: RTL and testbench

Character-LCD controller that sits directly downstream of the CPU top level. It consumes the 32-character text frame assembled there: instruction word, register value and per-stage instruction types. It drives an HD44780-compatible 16x2 panel over the 4-bit bus. The block runs the power-on initialisation sequence, then rewrites both display lines on each refresh request, with all bus timing generated from clk.

---
 rtl/lcd_text_driver.sv | 197 +++++++++++++++++++
 tb/tb_lcd_text_driver.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_driver.sv
// HD44780 16x2 character-LCD driver on the 4-bit bus. It runs the power-on init,
// then redraws both lines from a 32-byte text frame on each refresh request.
module lcd_text_driver #(
  parameter int T_POWERUP = 750000,
  parameter int T_INIT1   = 205000,
  parameter int T_INIT2   = 5000,
  parameter int T_E       = 12,
  parameter int T_NIB     = 50,
  parameter int T_CMD     = 2000,
  parameter int T_CLR     = 82000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         refresh,
  input  logic [255:0] text,
  output logic         ready,
  output logic         frame_done,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_e,
  output logic [3:0]   lcd_d
);

  typedef enum logic [2:0] {PWR_WAIT, INIT_NIB, INIT_CMD, IDLE, FRAME} state_t;
  typedef enum logic [1:0] {SETUP, PULSE, HOLD, WAIT} phase_t;

  state_t        state, state_n;
  phase_t        phase, phase_n;
  logic [19:0]   cnt, cnt_n, wait_m1;
  logic [5:0]    idx, idx_n, last_idx;
  logic          nib, nib_n;
  logic          pending, pending_n;
  logic          done_q, done_n;
  logic          load;
  logic [255:0]  shadow, shadow_n;
  logic [4:0]    bus_q, bus_n;
  logic [8:0]    cur_byte;

  // {rs, byte} for byte i of an init-command or frame sequence.
  function automatic logic [8:0] byte_of(state_t st, logic [5:0] i, logic [255:0] sh);
    logic [8:0] r;
    logic [4:0] c;
    logic [7:0] sel;
    r   = '0;
    c   = '0;
    sel = '0;
    case (st)
      INIT_CMD: begin
        case (i[1:0])
          2'd0:    r = {1'b0, 8'h28};
          2'd1:    r = {1'b0, 8'h0C};
          2'd2:    r = {1'b0, 8'h06};
          default: r = {1'b0, 8'h01};
        endcase
      end
      FRAME: begin
        if (i == 6'd0)       r = {1'b0, 8'h80};
        else if (i == 6'd17) r = {1'b0, 8'hC0};
        else begin
          c   = (i < 6'd17) ? 5'(i - 6'd1) : 5'(i - 6'd2);
          sel = {~c, 3'b000};
          r   = {1'b1, sh[sel +: 8]};
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [4:0] bus_of(state_t st, logic [5:0] i, logic n, logic [255:0] sh);
    logic [8:0] b;
    b = byte_of(st, i, sh);
    if (st == INIT_NIB) return {1'b0, (i == 6'd3) ? 4'h2 : 4'h3};
    return {b[8], n ? b[3:0] : b[7:4]};
  endfunction

  always_comb begin
    cur_byte = byte_of(state, idx, shadow);
    last_idx = (state == FRAME) ? 6'd33 : 6'd3;
    if (state == INIT_NIB) begin
      case (idx[1:0])
        2'd0:    wait_m1 = 20'(T_INIT1 - 1);
        2'd1:    wait_m1 = 20'(T_INIT2 - 1);
        default: wait_m1 = 20'(T_CMD - 1);
      endcase
    end else if (!nib)                   wait_m1 = 20'(T_NIB - 1);
    else if (cur_byte == {1'b0, 8'h01})  wait_m1 = 20'(T_CLR - 1);
    else                                 wait_m1 = 20'(T_CMD - 1);
  end

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    cnt_n     = cnt;
    idx_n     = idx;
    nib_n     = nib;
    pending_n = pending;
    shadow_n  = shadow;
    done_n    = 1'b0;
    load      = 1'b0;
    if (refresh && state != IDLE) pending_n = 1'b1;
    case (state)
      PWR_WAIT: begin
        if (cnt == '0) begin
          state_n = INIT_NIB;
          phase_n = SETUP;
          idx_n   = '0;
          nib_n   = 1'b0;
          load    = 1'b1;
        end else cnt_n = cnt - 20'd1;
      end
      IDLE: begin
        if (refresh || pending) begin
          state_n   = FRAME;
          phase_n   = SETUP;
          idx_n     = '0;
          nib_n     = 1'b0;
          shadow_n  = text;
          pending_n = 1'b0;
          load      = 1'b1;
        end
      end
      default: begin
        case (phase)
          SETUP: begin
            phase_n = PULSE;
            cnt_n   = 20'(T_E - 1);
          end
          PULSE: begin
            if (cnt == '0) phase_n = HOLD;
            else           cnt_n   = cnt - 20'd1;
          end
          HOLD: begin
            phase_n = WAIT;
            cnt_n   = wait_m1;
          end
          default: begin
            if (cnt != '0) cnt_n = cnt - 20'd1;
            else begin
              phase_n = SETUP;
              load    = 1'b1;
              if (state == INIT_NIB) begin
                if (idx == 6'd3) begin
                  state_n = INIT_CMD;
                  idx_n   = '0;
                end else idx_n = idx + 6'd1;
              end else if (!nib) begin
                nib_n = 1'b1;
              end else begin
                nib_n = 1'b0;
                if (idx == last_idx) begin
                  // Bus lines keep their last value while idle.
                  state_n = IDLE;
                  load    = 1'b0;
                  done_n  = (state == FRAME);
                end else idx_n = idx + 6'd1;
              end
            end
          end
        endcase
      end
    endcase
    bus_n = load ? bus_of(state_n, idx_n, nib_n, shadow_n) : bus_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= PWR_WAIT;
      phase   <= SETUP;
      cnt     <= 20'(T_POWERUP - 1);
      idx     <= '0;
      nib     <= 1'b0;
      pending <= 1'b0;
      done_q  <= 1'b0;
      shadow  <= '0;
      bus_q   <= '0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      nib     <= nib_n;
      pending <= pending_n;
      done_q  <= done_n;
      shadow  <= shadow_n;
      bus_q   <= bus_n;
    end
  end

  assign ready      = (state == IDLE);
  assign frame_done = done_q;
  assign lcd_rs     = bus_q[4];
  assign lcd_d      = bus_q[3:0];
  assign lcd_e      = (phase == PULSE);
  assign lcd_rw     = 1'b0;

endmodule

// File: tb/tb_lcd_text_driver.sv
// Bench for lcd_text_driver: bus monitor on lcd_e falls, init table, frame reference
// model, back-to-back and pending requests, asynchronous reset mid-frame.
module tb_lcd_text_driver;
  localparam int T_POWERUP = 20, T_INIT1 = 10, T_INIT2 = 5, T_E = 2;
  localparam int T_NIB = 3, T_CMD = 4, T_CLR = 8;
  localparam int BYTE_CYC  = 2 * T_E + T_NIB + T_CMD + 4;
  localparam int FRAME_CYC = 34 * BYTE_CYC;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         refresh = 1'b0;
  logic [255:0] text = '0;
  logic         ready, frame_done, lcd_rs, lcd_rw, lcd_e;
  logic [3:0]   lcd_d;
  logic [4:0]   bus_now;

  lcd_text_driver #(
    .T_POWERUP(T_POWERUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_E(T_E),
    .T_NIB(T_NIB), .T_CMD(T_CMD), .T_CLR(T_CLR)
  ) dut (
    .clk(clk), .rst(rst), .refresh(refresh), .text(text), .ready(ready),
    .frame_done(frame_done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_d(lcd_d)
  );

  always #5 clk = ~clk;
  assign bus_now = {lcd_rs, lcd_d};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus monitor: event times are edge numbers; bus captured as {rs, d} at each lcd_e fall.
  int         rise_t[$], fall_t[$], done_t[$], ready_t[$];
  logic [4:0] bus_q[$];
  logic [4:0] exp_q[$];
  logic       prev_e = 1'b0, prev_ready = 1'b0;
  logic [4:0] prev_bus = '0, held_bus = '0;
  int         hi_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      check("rw_low", longint'(lcd_rw), 0);
      if (lcd_e && !prev_e) begin
        rise_t.push_back(cyc);
        check("setup_stable", longint'(bus_now), longint'(prev_bus));
        held_bus <= bus_now;
        hi_cnt   <= 1;
      end else if (lcd_e) begin
        check("pulse_stable", longint'(bus_now), longint'(held_bus));
        hi_cnt <= hi_cnt + 1;
      end else if (prev_e) begin
        fall_t.push_back(cyc);
        check("e_width", longint'(hi_cnt), T_E);
        check("hold_stable", longint'(bus_now), longint'(held_bus));
        bus_q.push_back(bus_now);
      end
      if (frame_done) done_t.push_back(cyc);
      if (ready && !prev_ready) ready_t.push_back(cyc);
      prev_e     <= lcd_e;
      prev_ready <= ready;
      prev_bus   <= bus_now;
    end else begin
      prev_e     <= 1'b0;
      prev_ready <= 1'b0;
      prev_bus   <= '0;
    end
  end

  function automatic int qsize(input int which);
    case (which)
      0:       return ready_t.size();
      1:       return done_t.size();
      2:       return bus_q.size();
      default: return rise_t.size();
    endcase
  endfunction

  function automatic longint at(input int which, input int i);
    case (which)
      0:       return (i < ready_t.size()) ? longint'(ready_t[i]) : -1;
      1:       return (i < done_t.size())  ? longint'(done_t[i])  : -1;
      2:       return (i < bus_q.size())   ? longint'(bus_q[i])   : -1;
      3:       return (i < rise_t.size())  ? longint'(rise_t[i])  : -1;
      default: return (i < fall_t.size())  ? longint'(fall_t[i])  : -1;
    endcase
  endfunction

  task automatic clear_queues();
    rise_t.delete(); fall_t.delete(); done_t.delete(); ready_t.delete(); bus_q.delete();
  endtask

  task automatic wait_for(input int which, input int n, input int budget, input string name);
    int k;
    k = 0;
    while (qsize(which) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, longint'(qsize(which) >= n), 1);
  endtask

  task automatic pulse_refresh(output int edge_n);
    @(negedge clk);
    refresh = 1'b1;
    edge_n  = cyc + 1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  // Reference model: the bytes a frame must put on the bus, as nibbles.
  task automatic push_byte(input logic rs, input logic [7:0] b);
    exp_q.push_back({rs, b[7:4]});
    exp_q.push_back({rs, b[3:0]});
  endtask

  task automatic model_frame(input logic [255:0] t);
    logic [7:0]   chars [32];
    logic [255:0] s;
    s = t;
    for (int c = 31; c >= 0; c--) begin
      chars[c] = s[7:0];
      s = s >> 8;
    end
    exp_q.delete();
    push_byte(1'b0, 8'h80);
    for (int c = 0; c < 16; c++) push_byte(1'b1, chars[c]);
    push_byte(1'b0, 8'hC0);
    for (int c = 16; c < 32; c++) push_byte(1'b1, chars[c]);
  endtask

  task automatic check_frame(input int offset, input logic [255:0] t, input string name);
    int i;
    model_frame(t);
    i = 0;
    while (exp_q.size() > 0) begin
      check(name, at(2, offset + i), longint'(exp_q.pop_front()));
      i++;
    end
  endtask

  function automatic logic [255:0] rand_text();
    logic [255:0] t;
    for (int c = 0; c < 32; c++) t[8*c +: 8] = 8'($urandom_range(32, 126));
    return t;
  endfunction

  typedef struct {
    logic [4:0] bus;
    int         wait_cyc;
  } init_vec_t;
  init_vec_t init_tab [12];

  // Releases rst (caller holds it high) and checks the init nibbles and their spacing.
  task automatic run_init(input int ref_at);
    int rel;
    clear_queues();
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    if (ref_at > 0) begin
      repeat (ref_at) @(negedge clk);
      refresh = 1'b1;
      @(negedge clk);
      refresh = 1'b0;
    end
    wait_for(0, 1, 3000, "init_ready_timeout");
    check("init_first_rise", at(3, 0) - rel, T_POWERUP + 1);
    for (int i = 0; i < 12; i++) begin
      check("init_nibble", at(2, i), longint'(init_tab[i].bus));
      if (i < 11) check("init_gap", at(3, i + 1) - at(4, i), init_tab[i].wait_cyc + 2);
      else        check("init_ready_gap", at(0, 0) - at(4, i), init_tab[i].wait_cyc + 1);
    end
    check("init_no_done", longint'(done_t.size()), 0);
  endtask

  task automatic run_frame(input logic [255:0] t, input string name);
    int n;
    clear_queues();
    text = t;
    pulse_refresh(n);
    check("ready_drop", longint'(ready), 0);
    wait_for(1, 1, FRAME_CYC + 100, "frame_timeout");
    check("frame_first_rise", at(3, 0), n + 1);
    check("frame_duration", at(1, 0) - n, FRAME_CYC);
    check_frame(0, t, name);
    repeat (20) @(negedge clk);
    check("frame_done_once", longint'(done_t.size()), 1);
    check("ready_back", longint'(ready), 1);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, longint'({ready, frame_done, lcd_rs, lcd_rw, lcd_e}), 0);
    check(name, longint'(lcd_d), 0);
  endtask

  initial begin
    int n, m, k;
    logic [255:0] t1, t_a;
    init_tab[0]  = '{5'h03, T_INIT1};
    init_tab[1]  = '{5'h03, T_INIT2};
    init_tab[2]  = '{5'h03, T_CMD};
    init_tab[3]  = '{5'h02, T_CMD};
    init_tab[4]  = '{5'h02, T_NIB};
    init_tab[5]  = '{5'h08, T_CMD};
    init_tab[6]  = '{5'h00, T_NIB};
    init_tab[7]  = '{5'h0C, T_CMD};
    init_tab[8]  = '{5'h00, T_NIB};
    init_tab[9]  = '{5'h06, T_CMD};
    init_tab[10] = '{5'h00, T_NIB};
    init_tab[11] = '{5'h01, T_CLR};

    #2;
    check_outputs_zero("reset_outputs");
    repeat (2) @(negedge clk);
    run_init(0);

    run_frame("1234567887654321FD06|E03|M07|W0A", "frame_fixed");
    run_frame({32{8'h20}}, "frame_spaces");
    run_frame({32{8'h7E}}, "frame_tildes");
    for (int r = 0; r < 3; r++) run_frame(rand_text(), "frame_random");

    // Back-to-back: mid-frame text change must not leak into the running frame.
    clear_queues();
    t1   = rand_text();
    t_a  = {32{8'h41}};
    text = t1;
    pulse_refresh(n);
    wait_for(2, 20, FRAME_CYC, "b2b_mid_timeout");
    text = t_a;
    pulse_refresh(m);
    wait_for(1, 2, 2 * FRAME_CYC + 200, "b2b_timeout");
    repeat (FRAME_CYC + 50) @(negedge clk);
    check("b2b_done_count", longint'(done_t.size()), 2);
    check("b2b_nibble_count", longint'(bus_q.size()), 136);
    check("b2b_second_start", at(3, 68), at(1, 0) + 2);
    check("b2b_second_done", at(1, 1) - at(1, 0), FRAME_CYC + 1);
    check_frame(0, t1, "b2b_frame1");
    check_frame(68, t_a, "b2b_frame2");

    // Refresh during power-up wait: one frame right after init.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    t1   = rand_text();
    text = t1;
    run_init(5);
    wait_for(1, 1, FRAME_CYC + 200, "pend_timeout");
    check("pend_start", at(3, 12), at(0, 0) + 2);
    check_frame(12, t1, "pend_frame");
    repeat (FRAME_CYC) @(negedge clk);
    check("pend_done_count", longint'(done_t.size()), 1);
    check("pend_nibble_count", longint'(bus_q.size()), 80);

    // Asynchronous reset at byte 10 while lcd_e is high.
    clear_queues();
    text = rand_text();
    pulse_refresh(n);
    wait_for(2, 20, FRAME_CYC, "rst_mid_timeout");
    k = 0;
    while (!lcd_e && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rst_e_high", longint'(lcd_e), 1);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("rst_async_outputs");
    repeat (2) @(negedge clk);
    run_init(0);
    repeat (FRAME_CYC) @(negedge clk);
    check("rst_no_resume_done", longint'(done_t.size()), 0);
    check("rst_no_resume_bus", longint'(bus_q.size()), 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
